instr_mem_resp: RTL and testbench
=================================

Name: instr_mem_resp

Overview:
- Instruction-memory responder: the memory-side end of the fetch request/address/read-data interface.
- Accepts one word-read request per cycle from the fetch stage and returns the instruction word a fixed LATENCY cycles later, with a valid strobe and an error code.
- Includes a word-write load port that preloads the program before or between runs.
- Sits between the fetch stage and the instruction storage; also used as the bench memory for core-level tests.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words stored; power of two, at least 4.
- LATENCY, 1, request-to-response delay in cycles; legal range 1..4.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH_WORDS*4 aligned.
- NOP_INSTR, 32'h0000_0013, word returned on an errored read (addi x0,x0,0).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr_mem_req_i  in  1  read request, sampled every cycle, no backpressure.
- instr_mem_addr_i  in  32  byte address of requested word.
- instr_mem_rd_data_o  out  32  returned instruction word.
- instr_mem_rd_valid_o  out  1  rd_data/err valid this cycle.
- instr_mem_err_o  out  2  00 ok, 01 misaligned, 10 out of range.
- load_we_i  in  1  load-port word write enable.
- load_addr_i  in  32  load-port byte address.
- load_data_i  in  32  load-port write data.
- load_err_o  out  1  one-cycle pulse: previous-cycle load write was rejected.

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted:
  - all pipeline valid bits, rd_data_o, err_o and load_err_o are forced to 0;
  - memory array contents are not cleared.
- Reset mid-operation: all in-flight responses are dropped; no valid is produced for requests accepted before reset.
- First request is accepted on the first rising edge with reset low.
- Address decode:
  - off = addr - BASE_ADDR (32-bit wrap).
  - Index = off[2+IW-1:2], where IW = $clog2(DEPTH_WORDS).
  - Misaligned: addr[1:0] != 0.
  - Out of range: off >= DEPTH_WORDS*4; addresses below BASE_ADDR wrap to a large off and are out of range.
  - Misaligned takes priority over out of range.
- Read path:
  - A request in cycle N produces rd_valid_o=1 in cycle N+LATENCY (exactly), with data and err.
  - Fully pipelined: back-to-back requests give back-to-back responses in order.
  - Errored read: data = NOP_INSTR, err_o per the priority above.
  - The array is read at acceptance (stage 0); later stages only shift registered data/err.
- Idle cycles:
  - rd_valid_o=0; rd_data_o and err_o hold their last driven value.
  - Consumers must qualify on valid.
- Load path:
  - load_we_i with a legal address writes load_data_i at the decoded index on the clock edge.
  - Illegal address (misaligned or out of range): no write; load_err_o=1 in the next cycle.
- Simultaneous read and load to the same index in the same cycle: the read returns the OLD word (read-before-write); the next read returns the new word.
- No internal state machine beyond the LATENCY-stage valid/data/err shift pipeline; the block never stalls.

Decomposition:
- Shared package instr_mem_pkg:
  - typedef enum logic [1:0] resp_err_e {ERR_NONE, ERR_MISALIGN, ERR_RANGE};
  - localparam XLEN=32;
  - localparam NOP_INSTR_DEFAULT=32'h0000_0013.
- One sub-module: instr_mem_resp_pipe, a LATENCY-deep shift pipeline of {valid, data[31:0], err}.
  - Async active-high reset on valid/data/err.
  - Also instantiated by the future data-memory responder.
- Address decode and array stay in the top module.

Test Plan:
1. Reset then load: load words 0x0000_0093, 0x0010_0113 at addrs 0x0, 0x4; reset low; req addr 0x4 at cycle N -> cycle N+1 (LATENCY=1): valid=1, data=0x0010_0113, err=00.
2. Streaming: LATENCY=3; req 0x0, 0x4, 0x8 in consecutive cycles -> valid in cycles N+3..N+5, data in order, no gaps; valid=0 in cycle N+6.
3. Errors: req 0x6 -> err=01, data=0x0000_0013. Req 0x1000 with DEPTH_WORDS=1024 -> err=10, data=0x0000_0013. Req 0x1002 -> err=01 (misaligned priority).
4. Collision: word 0x8 holds 0xAAAA_AAAA; same cycle load 0x5555_5555 to 0x8 and req 0x8 -> response 0xAAAA_AAAA; next req 0x8 -> 0x5555_5555.
5. Load rejection: load_we to 0x0000_0002 -> load_err_o=1 for exactly one cycle; memory word 0x0 unchanged on readback.
6. Reset mid-flight: LATENCY=4; two requests issued, reset pulsed for 1 cycle asynchronously (not edge-aligned) -> rd_valid_o, rd_data_o, err_o drop to 0 immediately; no valid produced afterward for those requests; memory contents intact on subsequent reads.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the instruction/data memory responders.
package instr_mem_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_RANGE    = 2'b10
  } resp_err_e;

  // Misalignment wins over range; addresses below base wrap to a huge offset.
  function automatic resp_err_e addr_check(input logic [XLEN-1:0] addr,
                                           input logic [XLEN-1:0] base,
                                           input logic [XLEN-1:0] span);
    logic [XLEN-1:0] off;
    resp_err_e       res;
    off = addr - base;
    res = ERR_NONE;
    if (addr[1:0] != 2'b00) begin
      res = ERR_MISALIGN;
    end else if (off >= span) begin
      res = ERR_RANGE;
    end
    return res;
  endfunction

endpackage

// File: rtl/instr_mem_resp_if.sv
// Fetch read channel plus program load port of the instruction-memory responder.
interface instr_mem_resp_if;
  import instr_mem_pkg::*;

  logic            instr_mem_req_i;
  logic [XLEN-1:0] instr_mem_addr_i;
  logic [XLEN-1:0] instr_mem_rd_data_o;
  logic            instr_mem_rd_valid_o;
  resp_err_e       instr_mem_err_o;
  logic            load_we_i;
  logic [XLEN-1:0] load_addr_i;
  logic [XLEN-1:0] load_data_i;
  logic            load_err_o;

  modport master (
    output instr_mem_req_i, instr_mem_addr_i, load_we_i, load_addr_i, load_data_i,
    input  instr_mem_rd_data_o, instr_mem_rd_valid_o, instr_mem_err_o, load_err_o
  );

  modport slave (
    input  instr_mem_req_i, instr_mem_addr_i, load_we_i, load_addr_i, load_data_i,
    output instr_mem_rd_data_o, instr_mem_rd_valid_o, instr_mem_err_o, load_err_o
  );

endinterface

// File: rtl/instr_mem_resp_pipe.sv
// LATENCY-deep response pipeline of {valid, data, err}; payload only advances
// with a valid beat so the last stage holds the most recent response.
module instr_mem_resp_pipe
  import instr_mem_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_data,
  input  resp_err_e       in_err,
  output logic            out_valid,
  output logic [XLEN-1:0] out_data,
  output resp_err_e       out_err
);

  logic [LATENCY-1:0] valid_q;
  logic [XLEN-1:0]    data_q [LATENCY];
  resp_err_e          err_q  [LATENCY];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= '0;
        err_q[i]  <= ERR_NONE;
      end
    end else begin
      valid_q[0] <= in_valid;
      if (in_valid) begin
        data_q[0] <= in_data;
        err_q[0]  <= in_err;
      end
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) begin
          data_q[i] <= data_q[i-1];
          err_q[i]  <= err_q[i-1];
        end
      end
    end
  end

  always_comb begin
    out_valid = valid_q[LATENCY-1];
    out_data  = data_q[LATENCY-1];
    out_err   = err_q[LATENCY-1];
  end

endmodule

// File: rtl/instr_mem_resp.sv
// Instruction-memory responder: fixed-latency pipelined word reads with error
// codes, plus a word-write load port for program preload.
module instr_mem_resp
  import instr_mem_pkg::*;
#(
  parameter int unsigned     DEPTH_WORDS = 1024,
  parameter int unsigned     LATENCY     = 1,
  parameter logic [XLEN-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR   = NOP_INSTR_DEFAULT
) (
  input logic             clk,
  input logic             reset,
  instr_mem_resp_if.slave bus
);

  localparam int unsigned     IW   = $clog2(DEPTH_WORDS);
  localparam logic [XLEN-1:0] SPAN = DEPTH_WORDS * 4;

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];

  logic [IW-1:0]   rd_idx;
  resp_err_e       rd_err;
  logic [XLEN-1:0] rd_word;
  logic [XLEN-1:0] pipe_data;

  logic [IW-1:0]   ld_idx;
  resp_err_e       ld_err;
  logic            ld_ok;
  logic            load_err_q;

  // Out-of-range indices still land inside the array; their data is replaced by NOP.
  always_comb begin
    rd_idx    = IW'((bus.instr_mem_addr_i - BASE_ADDR) >> 2);
    rd_err    = addr_check(bus.instr_mem_addr_i, BASE_ADDR, SPAN);
    rd_word   = mem_q[rd_idx];
    pipe_data = (rd_err == ERR_NONE) ? rd_word : NOP_INSTR;
  end

  always_comb begin
    ld_idx = IW'((bus.load_addr_i - BASE_ADDR) >> 2);
    ld_err = addr_check(bus.load_addr_i, BASE_ADDR, SPAN);
    ld_ok  = bus.load_we_i && (ld_err == ERR_NONE);
  end

  // Array is read combinationally and captured by pipe stage 0 on the same edge
  // as the write, so a same-cycle read/load collision returns the old word.
  always_ff @(posedge clk) begin
    if (ld_ok) begin
      mem_q[ld_idx] <= bus.load_data_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= bus.load_we_i && !ld_ok;
    end
  end

  assign bus.load_err_o = load_err_q;

  instr_mem_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (bus.instr_mem_req_i),
    .in_data   (pipe_data),
    .in_err    (rd_err),
    .out_valid (bus.instr_mem_rd_valid_o),
    .out_data  (bus.instr_mem_rd_data_o),
    .out_err   (bus.instr_mem_err_o)
  );

endmodule

// File: tb/tb_instr_mem_resp.sv
// Bench for instr_mem_resp: three instances (LATENCY 1/3/4) driven in lockstep
// and checked every cycle against a cycle-indexed expected-response model.
`timescale 1ns/1ps
module tb_instr_mem_resp;
  import instr_mem_pkg::*;

  localparam int unsigned DEPTH = 1024;
  localparam int          NDUT  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [31:0] laddr = '0;
  logic [31:0] ldata = '0;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  instr_mem_resp_if f1 ();
  instr_mem_resp_if f3 ();
  instr_mem_resp_if f4 ();

  assign f1.instr_mem_req_i = req;   assign f1.instr_mem_addr_i = addr;
  assign f1.load_we_i = we;          assign f1.load_addr_i = laddr;
  assign f1.load_data_i = ldata;
  assign f3.instr_mem_req_i = req;   assign f3.instr_mem_addr_i = addr;
  assign f3.load_we_i = we;          assign f3.load_addr_i = laddr;
  assign f3.load_data_i = ldata;
  assign f4.instr_mem_req_i = req;   assign f4.instr_mem_addr_i = addr;
  assign f4.load_we_i = we;          assign f4.load_addr_i = laddr;
  assign f4.load_data_i = ldata;

  instr_mem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .bus(f1.slave));
  instr_mem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .bus(f3.slave));
  instr_mem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(4)) u_l4 (
    .clk(clk), .reset(reset), .bus(f4.slave));

  logic        o_v  [NDUT];
  logic [31:0] o_d  [NDUT];
  logic [1:0]  o_e  [NDUT];
  logic        o_le [NDUT];

  assign o_v[0] = f1.instr_mem_rd_valid_o; assign o_d[0] = f1.instr_mem_rd_data_o;
  assign o_e[0] = f1.instr_mem_err_o;      assign o_le[0] = f1.load_err_o;
  assign o_v[1] = f3.instr_mem_rd_valid_o; assign o_d[1] = f3.instr_mem_rd_data_o;
  assign o_e[1] = f3.instr_mem_err_o;      assign o_le[1] = f3.load_err_o;
  assign o_v[2] = f4.instr_mem_rd_valid_o; assign o_d[2] = f4.instr_mem_rd_data_o;
  assign o_e[2] = f4.instr_mem_err_o;      assign o_le[2] = f4.load_err_o;

  // Reference model: word array plus expected responses indexed by cycle number.
  logic [31:0] mem_m  [DEPTH];
  logic        sv     [NDUT][8];
  logic [31:0] sd     [NDUT][8];
  logic [1:0]  se     [NDUT][8];
  logic [31:0] last_d [NDUT];
  logic [1:0]  last_e [NDUT];
  logic        le_s   [8];

  int checks = 0;
  int errors = 0;

  function automatic int lat_of(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic logic [1:0] ref_err(input logic [31:0] a);
    if (a % 4 != 0) return 2'd1;
    if (a >= DEPTH * 4) return 2'd2;
    return 2'd0;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d cyc%0d: observed %h expected %h", tag, k, cyc, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NDUT; k++) begin
      for (int s = 0; s < 8; s++) sv[k][s] = 1'b0;
      last_d[k] = '0;
      last_e[k] = '0;
    end
    for (int s = 0; s < 8; s++) le_s[s] = 1'b0;
  endtask

  task automatic check_cycle();
    int slot;
    slot = cyc % 8;
    for (int k = 0; k < NDUT; k++) begin
      if (sv[k][slot]) begin
        last_d[k] = sd[k][slot];
        last_e[k] = se[k][slot];
      end
      chk("valid", k, 32'(o_v[k]), 32'(sv[k][slot]));
      chk("data", k, o_d[k], last_d[k]);
      chk("err", k, 32'(o_e[k]), 32'(last_e[k]));
      chk("load_err", k, 32'(o_le[k]), 32'(le_s[slot]));
      sv[k][slot] = 1'b0;
    end
    le_s[slot] = 1'b0;
  endtask

  // Called at a negedge: inputs are sampled by the next posedge.
  task automatic drive(input logic r, input logic [31:0] a, input logic w,
                       input logic [31:0] la, input logic [31:0] ld);
    logic [1:0]  e;
    logic [31:0] d;
    int          slot;
    req = r; addr = a; we = w; laddr = la; ldata = ld;
    if (!reset) begin
      if (r) begin
        e = ref_err(a);
        d = (e == 2'd0) ? mem_m[(a / 4) % DEPTH] : 32'h0000_0013;
        for (int k = 0; k < NDUT; k++) begin
          slot = (cyc + lat_of(k)) % 8;
          sv[k][slot] = 1'b1;
          sd[k][slot] = d;
          se[k][slot] = e;
        end
      end
      if (w && ref_err(la) != 2'd0) le_s[(cyc + 1) % 8] = 1'b1;
    end
    if (w && ref_err(la) == 2'd0) mem_m[la / 4] = ld;
    @(posedge clk);
    @(negedge clk);
    check_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  logic [31:0] ra, la, ldv;
  logic        rr, rw;
  int          sel;

  initial begin
    model_clear();
    // Preload while in reset: random fill, then the directed words.
    for (int i = 0; i < DEPTH; i++) drive(1'b0, 32'h0, 1'b1, 32'(i * 4), $urandom);
    drive(1'b0, 32'h0, 1'b1, 32'h0, 32'h0000_0093);
    drive(1'b0, 32'h0, 1'b1, 32'h4, 32'h0010_0113);
    drive(1'b0, 32'h0, 1'b1, 32'h8, 32'hAAAA_AAAA);
    reset = 1'b0;

    drive(1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
    chk("t1_valid", 0, 32'(o_v[0]), 32'd1);
    chk("t1_data", 0, o_d[0], 32'h0010_0113);
    chk("t1_err", 0, 32'(o_e[0]), 32'd0);
    idle(4);

    drive(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 32'h8, 1'b0, 32'h0, 32'h0);
    chk("t2_d0", 1, o_d[1], 32'h0000_0093);
    idle(1);
    chk("t2_d1", 1, o_d[1], 32'h0010_0113);
    idle(1);
    chk("t2_d2", 1, o_d[1], 32'hAAAA_AAAA);
    chk("t2_v2", 1, 32'(o_v[1]), 32'd1);
    idle(1);
    chk("t2_gap", 1, 32'(o_v[1]), 32'd0);
    idle(3);

    drive(1'b1, 32'h6, 1'b0, 32'h0, 32'h0);
    chk("t3_mis_err", 0, 32'(o_e[0]), 32'd1);
    chk("t3_mis_data", 0, o_d[0], 32'h0000_0013);
    drive(1'b1, 32'h1000, 1'b0, 32'h0, 32'h0);
    chk("t3_rng_err", 0, 32'(o_e[0]), 32'd2);
    chk("t3_rng_data", 0, o_d[0], 32'h0000_0013);
    drive(1'b1, 32'h1002, 1'b0, 32'h0, 32'h0);
    chk("t3_prio_err", 0, 32'(o_e[0]), 32'd1);
    idle(4);

    drive(1'b1, 32'h8, 1'b1, 32'h8, 32'h5555_5555);
    chk("t4_old", 0, o_d[0], 32'hAAAA_AAAA);
    drive(1'b1, 32'h8, 1'b0, 32'h0, 32'h0);
    chk("t4_new", 0, o_d[0], 32'h5555_5555);
    idle(4);

    drive(1'b0, 32'h0, 1'b1, 32'h2, 32'h1234_5678);
    chk("t5_lerr", 0, 32'(o_le[0]), 32'd1);
    drive(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("t5_lerr_gone", 0, 32'(o_le[0]), 32'd0);
    chk("t5_word0", 0, o_d[0], 32'h0000_0093);
    idle(4);

    // Random mix of legal/misaligned/out-of-range reads and loads.
    for (int i = 0; i < 400; i++) begin
      rr  = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 9);
      if (sel < 7)       ra = {20'h0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
      else if (sel == 7) ra = {20'h0, 10'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
      else if (sel == 8) ra = 32'h1000 + {$urandom_range(0, 4095), 2'b00};
      else               ra = $urandom;
      rw  = ($urandom_range(0, 2) == 0);
      la  = ($urandom_range(0, 4) == 0) ? $urandom : {20'h0, 10'($urandom_range(0, 15)), 2'b00};
      ldv = $urandom;
      drive(rr, ra, rw, la, ldv);
    end
    idle(5);

    // Asynchronous reset pulse with requests in flight.
    drive(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
    req = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk("rst_valid", k, 32'(o_v[k]), 32'd0);
      chk("rst_data", k, o_d[k], 32'd0);
      chk("rst_err", k, 32'(o_e[k]), 32'd0);
    end
    #8;
    reset = 1'b0;
    @(negedge clk);
    check_cycle();
    idle(6);
    drive(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 32'hFFC, 1'b0, 32'h0, 32'h0);
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
